// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and
// small opcode classification helpers.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_t;

  function automatic imm_t imm_type(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, one write
// port committed at the clock edge, x0 hardwired to zero.
module regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data
);

  logic [XLEN-1:0] r_mem [NREG];

  // NOTE: this array is reset on purpose (cleared state is architectural);
  // it costs a RAM macro, so arrays without that need should not be reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_rd_addr != '0)) begin
      r_mem[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID pipeline register, register file, immediates.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle writeback into capture.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [31:0]     id_imm,
  output logic            id_illegal
);

  logic            r_valid;
  logic [31:0]     r_pc;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [4:0]      r_rd;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [31:0]     r_imm;
  logic            r_illegal;

  logic            w_capture;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_rs1_op;
  logic [XLEN-1:0] w_rs2_op;
  logic [31:0]     w_imm;
  logic            w_wb_live;

  assign id_ready  = !r_valid || ex_ready;
  assign w_capture = if_valid && id_ready && !flush;
  assign w_opcode  = if_instr[6:0];
  assign w_rs1     = if_instr[19:15];
  assign w_rs2     = if_instr[24:20];
  assign w_wb_live = wb_we && (wb_rd != '0);

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rf_rs1),
    .o_rs2_data (w_rf_rs2),
    .i_we       (wb_we),
    .i_rd_addr  (wb_rd),
    .i_rd_data  (wb_data)
  );

`ifdef ID_WB_BYPASS_EN
  assign w_rs1_op = (w_wb_live && (wb_rd == w_rs1)) ? wb_data : w_rf_rs1;
  assign w_rs2_op = (w_wb_live && (wb_rd == w_rs2)) ? wb_data : w_rf_rs2;
`else
  // Pre-write contents; the hazard unit covers the one-cycle gap.
  assign w_rs1_op = w_rf_rs1;
  assign w_rs2_op = w_rf_rs2;
`endif

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_imm = '0;
    case (imm_type(w_opcode))
      IMM_I: w_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      IMM_S: w_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      IMM_B: w_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
      IMM_U: w_imm = {if_instr[31:12], 12'b0};
      IMM_J: w_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (ex_ready)  r_valid <= 1'b0;

      if (w_capture) begin
        r_pc      <= if_pc;
        r_opcode  <= w_opcode;
        r_funct3  <= if_instr[14:12];
        r_funct7  <= if_instr[31:25];
        r_rd      <= if_instr[11:7];
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rs1_val <= w_rs1_op;
        r_rs2_val <= w_rs2_op;
        r_imm     <= w_imm;
        r_illegal <= !is_legal(w_opcode);
      end else if (r_valid && w_wb_live) begin
        // Keep a stalled instruction's operands current with writeback.
        if (wb_rd == r_rs1) r_rs1_val <= wb_data;
        if (wb_rd == r_rs2) r_rs2_val <= wb_data;
      end
    end
  end

  assign id_valid   = r_valid;
  assign id_pc      = r_pc;
  assign id_opcode  = r_opcode;
  assign id_funct3  = r_funct3;
  assign id_funct7  = r_funct7;
  assign id_rd      = r_rd;
  assign id_rs1     = r_rs1;
  assign id_rs2     = r_rs2;
  assign id_rs1_val = r_rs1_val;
  assign id_rs2_val = r_rs2_val;
  assign id_imm     = r_imm;
  assign id_illegal = r_illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the pipelined RV32I core. It consumes the fetch stage's `pc`/`instr` stream through a valid/ready handshake and holds the IF/ID pipeline register. It also owns the architectural register file, decodes fields and immediates, and presents registered operands to execute. Writeback writes the register file through a dedicated port.

## Interface
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural registers; x0 hardwired to zero
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `if_valid`  in  1  fetch presents a valid instruction
- `if_pc`  in  32  PC of presented instruction
- `if_instr`  in  32  presented instruction word
- `id_ready`  out  1  stage accepts an instruction this cycle
- `flush`  in  1  kill held instruction and drop incoming one
- `ex_ready`  in  1  execute accepts the held instruction
- `wb_we`  in  1  writeback write enable
- `wb_rd`  in  5  writeback destination
- `wb_data`  in  32  writeback value
- `id_valid`  out  1  held instruction valid
- `id_pc`  out  32  PC of held instruction
- `id_opcode`/`id_funct3`/`id_funct7`  out  7/3/7  decoded fields
- `id_rd`/`id_rs1`/`id_rs2`  out  5 each  register indices
- `id_rs1_val`/`id_rs2_val`  out  32 each  operand values
- `id_imm`  out  32  sign-extended immediate
- `id_illegal`  out  1  opcode not in RV32I base set

## Operation
- `id_ready = !id_valid || ex_ready`, combinational. Capture occurs when `if_valid && id_ready && !flush`.
- On capture, register the PC and all decoded fields. Read the register file combinationally at capture and register the operand values.
- Immediate format is selected by opcode:
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Every other type (R-type 0110011, fence, system): imm = 0.
- For any other opcode, `id_illegal=1` and imm = 0, but the instruction is still passed with `id_valid=1`.
- `id_valid` next-state rules:
  - `flush`: 0, highest priority, and the incoming instruction is dropped.
  - Capture: 1.
  - `ex_ready && !capture`: 0.
  - Otherwise: hold.
- Held-operand refresh: while an instruction is held and not being replaced, a `wb_we` to a nonzero `wb_rd` matching `id_rs1`/`id_rs2` updates the corresponding `*_val`.
- x0 rules: writes to x0 are ignored; x0 reads 0; x0 is never bypassed or refreshed.

## Timing
- Latency: one cycle. An instruction captured at edge N is visible on `id_*` after edge N.
- Throughput: one instruction per cycle when `ex_ready` is held high.
- Register file write takes effect at the edge.
- Reset: `id_valid=0`, `id_illegal=0`, and all other `id_*` outputs 0. All registers are cleared to 0. Reset mid-stall discards the held instruction.
- Simultaneous flush and `ex_ready`: flush wins and `id_valid` goes to 0.
- Simultaneous capture and `wb_we`: the register-file write always completes. Operand value depends on the configuration below.

## Configuration
- `ID_WB_BYPASS_EN` defined: on a capture-cycle `wb_we` whose `wb_rd` matches the new rs1/rs2 (nonzero), the registered operand takes `wb_data`. This is write-first behaviour.
- Undefined: the captured operand is the pre-write register-file contents. The hazard unit must then stall one extra cycle.

## Structure
- Shared package `riscv_pkg`:
  - opcode localparams (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`, `OP_FENCE`, `OP_SYSTEM`)
  - immediate-type enum `imm_t` (I/S/B/U/J/NONE)
- One sub-module, `regfile`:
  - two combinational read ports and one synchronous write port
  - synchronous reset clears all entries
  - x0 masking
- Immediate generation and the pipeline register stay in `id_stage`.

## Test plan
- Reset, then `if_instr=0x00500093` (addi x1,x0,5), `ex_ready=1`, `if_valid=1` -> next cycle: `id_valid=1`, `id_rd=1`, `id_rs1=0`, `id_imm=5`, `id_opcode=0x13`, `id_rs1_val=0`.
- `wb_we` x2=0x1234 in the same cycle as capturing `0x002101B3` (add x3,x2,x2) -> `id_rs1_val=id_rs2_val=0x1234` with the macro, 0 without. Both builds read 0x1234 on the next capture.
- Capture, then `ex_ready=0` for 3 cycles -> `id_ready=0`, outputs stable, new `if_instr` not taken. A `wb_we` to the held rs1 with 0xBEEF updates `id_rs1_val` to 0xBEEF.
- `flush=1` with `if_valid=1`, `id_ready=1` -> `id_valid=0` next cycle. The instruction is not captured.
- `0xFE000EE3` (beq x0,x0,-4) -> `id_imm=0xFFFFFFFC`. `0x12345037` (lui x0) -> `id_imm=0x12345000`, `id_rd=0`.
- `0x00000000` -> `id_illegal=1`, `id_imm=0`. `wb_we` to x0 with 0xFFFF, then read x0 -> 0.
